// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC angle constants, sign-flag encodings and the
// sign-correction helper used on both output channels.
package cordic_pkg;
   localparam logic signed [31:0] ANG_90     = 32'sd5898240;
   localparam logic signed [31:0] ANG_180    = 32'sd11796480;
   localparam logic signed [1:0]  SINAL_POS  = 2'sd1;
   localparam logic signed [1:0]  SINAL_NEG  = -2'sd1;
   localparam logic signed [1:0]  SINAL_ZERO = 2'sd0;
   localparam int                 MAXW       = 64;

   typedef struct packed {
      logic [1:0] seno;
      logic [1:0] cosseno;
   } tag_t;

   // Works on the low w bits of v; negating the most-negative value saturates.
   function automatic logic [MAXW-1:0] aplica_sinal(input logic [1:0] sinal,
                                                    input logic [MAXW-1:0] v,
                                                    input int w);
      logic [MAXW-1:0] msk, mn, x;
      msk = (w >= MAXW) ? '1 : (MAXW'(1) << w) - MAXW'(1);
      mn  = MAXW'(1) << (w - 1);
      x   = v & msk;
      if (sinal == 2'b00) return '0;
      if (!sinal[1]) return x;
      return (x == mn) ? mn - MAXW'(1) : (MAXW'(0) - x) & msk;
   endfunction
endpackage

// File: rtl/fila_sinais.sv
// fila_sinais: synchronous circular FIFO for the per-sample sign tags.
module fila_sinais #(
   parameter int DEPTH = 16,
   parameter int W     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/correcao_quadrante_saida.sv
// correcao_quadrante_saida: applies queued quadrant sign tags to raw CORDIC
// sine/cosine results behind a registered valid/ready output stage.
module correcao_quadrante_saida
   import cordic_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ITERATIONS = 16,
   parameter int TAG_DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tag_push,
   input  logic [1:0]                 tag_sinal_seno,
   input  logic [1:0]                 tag_sinal_cosseno,
   output logic                       tag_full,
   output logic [$clog2(TAG_DEPTH):0] tag_count,
   input  logic                       cordic_valid,
   input  logic [WIDTH-1:0]           cordic_seno,
   input  logic [WIDTH-1:0]           cordic_cosseno,
   output logic                       cordic_ready,
   output logic [WIDTH-1:0]           seno_out,
   output logic [WIDTH-1:0]           cosseno_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       err_overflow,
   output logic                       err_underflow
);
   if (TAG_DEPTH < ITERATIONS || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_param_check
      $error("TAG_DEPTH must be a power of two not smaller than ITERATIONS");
   end

   logic [3:0] tag_fifo;
   logic       vazia, accept, pop_ok;
   tag_t       tag;

   assign cordic_ready = !out_valid || out_ready;
   assign accept       = cordic_valid && cordic_ready;
   assign pop_ok       = accept && !vazia;

   fila_sinais #(.DEPTH(TAG_DEPTH), .W($bits(tag_t))) u_fila (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_push),
      .pop   (accept),
      .din   ({tag_sinal_seno, tag_sinal_cosseno}),
      .dout  (tag_fifo),
      .full  (tag_full),
      .empty (vazia),
      .count (tag_count)
   );

   // With no tag available the raw result passes unchanged.
   always_comb tag = vazia ? {SINAL_POS, SINAL_POS} : tag_fifo;

   always_ff @(posedge clk)
      if (rst) begin
         out_valid     <= 1'b0;
         seno_out      <= '0;
         cosseno_out   <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (accept) begin
            out_valid   <= 1'b1;
            seno_out    <= WIDTH'(aplica_sinal(tag.seno, MAXW'(cordic_seno), WIDTH));
            cosseno_out <= WIDTH'(aplica_sinal(tag.cosseno, MAXW'(cordic_cosseno), WIDTH));
         end else if (out_ready) out_valid <= 1'b0;
         if (tag_push && tag_full && !pop_ok) err_overflow <= 1'b1;
         if (accept && vazia) err_underflow <= 1'b1;
      end
endmodule
